intc_prio: RTL
==============

# intc_prio

Parametrised interrupt controller for the processor subsystem: collects `NUM_SRC` accelerator `done` lines, edge-latches them into pending bits, and arbitrates by fixed or round-robin priority. It raises `IRQ` to the core with a stable ISR vector and source ID. It tracks one in-service interrupt through an IACK/EOI handshake. Compared with the 4-source controller, it adds per-source masking, edge detection, lost-event reporting, end-of-interrupt sequencing and selectable arbitration.

## Interface
- `NUM_SRC`, 8, number of interrupt sources (2..32)
- `ADDR_W`, 32, ISR vector width
- `RR_MODE`, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- `ID_W`, $clog2(NUM_SRC), width of source ID (derived, not overridden)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, all state on rising edge
- `rst_ext` in 1: synchronous active-high reset
- `done` in NUM_SRC: per-source completion level; rising edge = interrupt event
- `mask` in NUM_SRC: 1 = source enabled for arbitration
- `isr_addr_flat` in NUM_SRC*ADDR_W: vector of source i at bits [i*ADDR_W +: ADDR_W]
- `IACK` in 1: core acknowledge, single-cycle pulse
- `EOI` in 1: core end-of-interrupt, single-cycle pulse
- `IRQ` out 1: interrupt request to core (registered)
- `isr_addr` out ADDR_W: vector of the granted source (registered)
- `irq_id` out ID_W: index of the granted source (registered)
- `pending` out NUM_SRC: pending status register
- `lost` out NUM_SRC: one-cycle pulse, event arrived on an already-pending source

## Operation
- Edge detect: `done_q` registered copy of `done`; `rise = done & ~done_q`.
- Pending: bit i set on `rise[i]`, cleared when source i is acknowledged. Set wins over clear in the same cycle. Masked sources still latch pending but do not request.
- `lost[i]` = `rise[i] & pending[i]` (registered pulse). The event is merged, not queued.
- `eligible = pending & mask`.
- Fixed mode: winner = lowest set index of `eligible`.
- RR mode: search starts at `last+1`, wraps modulo NUM_SRC. `last` updates to the winner on IACK.
- FSM states:
  - IDLE: if `eligible != 0`, latch winner into `irq_id` and `isr_addr`, go to REQ.
  - REQ: `IRQ=1`; `irq_id`/`isr_addr` frozen. On `IACK`: clear `pending[irq_id]`, `IRQ=0`, go to SERVICE.
  - SERVICE: `IRQ=0`; on `EOI`, go to IDLE.
- Mask or pending changes during REQ do not retract or change the latched request.
- Ignored inputs: `IACK` in IDLE/SERVICE, `EOI` in IDLE/REQ.
- No nesting: at most one interrupt in REQ or SERVICE.
- Reset values:
  - `IRQ`, `isr_addr`, `irq_id`, `pending`, `lost`, `done_q` = 0
  - state = IDLE
  - `last` = NUM_SRC-1, so source 0 has first priority in RR.
- `rst_ext` mid-operation drops `IRQ` and all pending events next edge, with no EOI required.

## Timing
- `done[i]` sampled high at edge k (low at k-1): `pending[i]` = 1 after k; FSM enters REQ at k+1; `IRQ` high after k+1. Latency is 2 cycles.
- `IACK` sampled at edge m: `IRQ` = 0 and pending bit cleared after m.
- `EOI` at edge n: IDLE after n; next `IRQ` earliest after n+1.
- `done` held high through reset release: treated as a rise on the first post-reset edge.
- `isr_addr` and `irq_id` are valid whenever `IRQ` = 1 and held until the next REQ entry.

## Test plan
- Single source: NUM_SRC=8, pulse `done[5]`, mask all 1 -> `IRQ` 2 cycles later, `irq_id`=5, `isr_addr`=vector5. `IACK` -> `pending[5]`=0 and `IRQ`=0. `EOI` -> IDLE.
- Fixed priority: `done[2]`,`done[6]` rise same cycle -> grant 2. After IACK+EOI -> grant 6. Still-pending 6 is not lost.
- Round-robin (RR_MODE=1): sources 0,1,3 permanently re-pulsed after each EOI -> grant order 0,1,3,0,1,3. No source is starved.
- Mask: `done[4]` rises with `mask[4]`=0 -> `pending[4]`=1, `IRQ` stays 0. Set `mask[4]`=1 -> `IRQ` within 2 cycles, `irq_id`=4.
- Lost and simultaneous cases:
  - Second rise on `done[3]` while `pending[3]`=1 -> `lost[3]` single-cycle pulse, one IRQ only.
  - Rise coincident with its own IACK -> pending stays 1.
- Reset mid-SERVICE and spurious handshakes:
  - Assert `rst_ext` in SERVICE -> all outputs 0 next cycle, state IDLE.
  - `IACK` in IDLE and `EOI` in REQ -> no state change.

Source files
------------

// File: rtl/intc_prio.sv
// Priority interrupt controller: edge-latches NUM_SRC done lines into pending bits,
// arbitrates fixed or round-robin, and tracks one interrupt through IACK/EOI.
module intc_prio #(
    parameter  int NUM_SRC = 8,
    parameter  int ADDR_W  = 32,
    parameter  int RR_MODE = 0,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_ext,
    input  logic [NUM_SRC-1:0]        done,
    input  logic [NUM_SRC-1:0]        mask,
    input  logic [NUM_SRC*ADDR_W-1:0] isr_addr_flat,
    input  logic                      IACK,
    input  logic                      EOI,
    output logic                      IRQ,
    output logic [ADDR_W-1:0]         isr_addr,
    output logic [ID_W-1:0]           irq_id,
    output logic [NUM_SRC-1:0]        pending,
    output logic [NUM_SRC-1:0]        lost
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_SRC-1:0]  r_done_q;
    logic [NUM_SRC-1:0]  r_pending;
    logic [NUM_SRC-1:0]  r_lost;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_irq_id;
    logic [ADDR_W-1:0]   r_isr_addr;
    logic                r_irq;

    logic [NUM_SRC-1:0]  w_rise;
    logic [NUM_SRC-1:0]  w_eligible;
    logic [NUM_SRC-1:0]  w_clr;
    logic [ID_W-1:0]     w_winner;
    logic                w_grant;
    logic                w_ack;
    logic                w_irq_nxt;

    function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        return ID_W'(sum);
    endfunction

    assign w_rise     = done & ~r_done_q;
    assign w_eligible = r_pending & mask;

    // Loops run from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_winner = '0;
        if (RR_MODE == 0) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (w_eligible[i]) w_winner = ID_W'(i);
            end
        end else begin
            for (int off = NUM_SRC; off >= 1; off--) begin
                if (w_eligible[wrap_idx(int'(r_last), off)]) w_winner = wrap_idx(int'(r_last), off);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_ext) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (|w_eligible) w_state_nxt = S_REQ;
            S_REQ:     if (IACK)        w_state_nxt = S_SERVICE;
            S_SERVICE: if (EOI)         w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath control decoded from the current state
    always_comb begin
        w_grant   = (r_state == S_IDLE) && (|w_eligible);
        w_ack     = (r_state == S_REQ) && IACK;
        w_irq_nxt = (w_state_nxt == S_REQ);
        w_clr     = '0;
        if (w_ack) w_clr[r_irq_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_ext) begin
            r_done_q   <= '0;
            r_pending  <= '0;
            r_lost     <= '0;
            r_last     <= ID_W'(NUM_SRC - 1);
            r_irq_id   <= '0;
            r_isr_addr <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_done_q  <= done;
            // NOTE: rise is OR-ed in after the clear so a new event in the ack cycle survives.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_lost    <= w_rise & r_pending;
            r_irq     <= w_irq_nxt;
            if (w_grant) begin
                r_irq_id   <= w_winner;
                r_isr_addr <= isr_addr_flat[int'(w_winner)*ADDR_W +: ADDR_W];
            end
            if (w_ack) r_last <= r_irq_id;
        end
    end

    assign IRQ      = r_irq;
    assign isr_addr = r_isr_addr;
    assign irq_id   = r_irq_id;
    assign pending  = r_pending;
    assign lost     = r_lost;

endmodule
